// File: rtl/tlc_pkg.sv
// Shared types and default timing for the phase scheduler.
package tlc_pkg;

    // Signal head indication
    typedef enum logic [2:0] {
        OFF       = 3'd0,
        RED       = 3'd1,
        YELLOW    = 3'd2,
        GREEN     = 3'd3,
        PRE_GREEN = 3'd4
    } lights_t;

    // Scheduler phases
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED   = 3'd2,
        EW_PREGRN = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6,
        NS_PREGRN = 3'd7
    } state_t;

    // Which side phase was granted most recently (round-robin tie break)
    typedef enum logic {
        SERVED_EW  = 1'b0,
        SERVED_PED = 1'b1
    } served_t;

    // Default phase durations in clock cycles
    localparam int unsigned GREEN_MIN_DEF = 4;
    localparam int unsigned GREEN_MAX_DEF = 8;
    localparam int unsigned YELLOW_T_DEF  = 2;
    localparam int unsigned ALLRED_T_DEF  = 1;
    localparam int unsigned PREGRN_T_DEF  = 1;
    localparam int unsigned WALK_T_DEF    = 4;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_count
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : int'($clog2(max_count + 1));
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter: clears on request, otherwise counts up and sticks at all-ones.
module phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    // Count cycles spent in the current phase, saturating so long holds never wrap
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (!w_at_max) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/phase_scheduler.sv
// Traffic phase scheduler: NS is the home phase; EW and pedestrian phases are
// granted on demand, always separated by yellow and all-red clearance, with
// emergency preemption steering right-of-way back to NS.
module phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned GREEN_MIN = GREEN_MIN_DEF,
    parameter int unsigned GREEN_MAX = GREEN_MAX_DEF,
    parameter int unsigned YELLOW_T  = YELLOW_T_DEF,
    parameter int unsigned ALLRED_T  = ALLRED_T_DEF,
    parameter int unsigned PREGRN_T  = PREGRN_T_DEF,
    parameter int unsigned WALK_T    = WALK_T_DEF
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_ew_sensor,
    input  logic    i_ped_req,
    input  logic    i_emgcy_sensor,
    output lights_t o_ns_light,
    output lights_t o_ew_light,
    output logic    o_walk
);

    // Timer must reach the largest "last cycle" index of any phase
    localparam int unsigned MAX_DUR = max2(max2(max2(GREEN_MIN, GREEN_MAX), max2(YELLOW_T, ALLRED_T)),
                                           max2(PREGRN_T, WALK_T));
    localparam int unsigned TIMER_W = count_width(MAX_DUR);

    // Timer value during the final cycle of each phase (durations assumed >= 1)
    localparam logic [TIMER_W-1:0] GMIN_LAST = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_LAST = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ARED_LAST = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] PRE_LAST  = TIMER_W'(PREGRN_T - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST = TIMER_W'(WALK_T - 1);

    state_t               r_state;
    state_t               w_state_next;
    state_t               w_arb_state;
    logic                 r_ew_pending;
    logic                 r_ped_pending;
    logic                 r_from_ns;
    served_t              r_last_served;
    logic [TIMER_W-1:0]   w_timer;
    logic                 w_state_change;
    logic                 w_enter_ew_pregrn;
    logic                 w_enter_walk;
    logic                 w_enter_all_red;

    assign w_state_change    = (w_state_next != r_state);
    assign w_enter_ew_pregrn = w_state_change && (w_state_next == EW_PREGRN);
    assign w_enter_walk      = w_state_change && (w_state_next == WALK);
    assign w_enter_all_red   = w_state_change && (w_state_next == ALL_RED);

    phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_state_change),
        .o_count (w_timer)
    );

    // Pick the phase that follows all-red clearance
    always_comb begin
        w_arb_state = NS_PREGRN;
        // Side phases only follow an NS phase; otherwise NS takes the road back
        if (!i_emgcy_sensor && r_from_ns) begin
            if (r_ew_pending && r_ped_pending) begin
                w_arb_state = (r_last_served == SERVED_PED) ? EW_PREGRN : WALK;
            end else if (r_ew_pending) begin
                w_arb_state = EW_PREGRN;
            end else if (r_ped_pending) begin
                w_arb_state = WALK;
            end
        end
    end

    // Next-phase selection from dwell time, demand and preemption
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            NS_GREEN: begin
                if (w_timer >= GMIN_LAST && !i_emgcy_sensor && (r_ew_pending || r_ped_pending)) begin
                    w_state_next = NS_YELLOW;
                end
            end
            NS_YELLOW, EW_YELLOW: begin
                // Yellow always runs its full length, even under preemption
                if (w_timer >= YEL_LAST) begin
                    w_state_next = ALL_RED;
                end
            end
            ALL_RED: begin
                if (w_timer >= ARED_LAST) begin
                    w_state_next = w_arb_state;
                end
            end
            EW_PREGRN: begin
                if (i_emgcy_sensor) begin
                    w_state_next = EW_YELLOW;
                end else if (w_timer >= PRE_LAST) begin
                    w_state_next = EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (i_emgcy_sensor || (w_timer == GMAX_LAST) ||
                    (w_timer >= GMIN_LAST && !i_ew_sensor)) begin
                    w_state_next = EW_YELLOW;
                end
            end
            WALK: begin
                if (i_emgcy_sensor || w_timer >= WALK_LAST) begin
                    w_state_next = ALL_RED;
                end
            end
            NS_PREGRN: begin
                if (w_timer >= PRE_LAST) begin
                    w_state_next = NS_GREEN;
                end
            end
            default: w_state_next = NS_GREEN;
        endcase
    end

    // Phase register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= NS_GREEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // EW demand: latched outside EW service, dropped once EW service starts
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ew_pending <= 1'b0;
        end else if (w_enter_ew_pregrn) begin
            r_ew_pending <= 1'b0;
        end else if (i_ew_sensor && r_state != EW_PREGRN && r_state != EW_GREEN) begin
            r_ew_pending <= 1'b1;
        end
    end

    // Pedestrian demand: a press in the cycle WALK is granted is kept for next time
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ped_pending <= 1'b0;
        end else if (i_ped_req && r_state != WALK) begin
            r_ped_pending <= 1'b1;
        end else if (w_enter_walk) begin
            r_ped_pending <= 1'b0;
        end
    end

    // Round-robin memory and origin of the current all-red interval
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_served <= SERVED_PED;
            r_from_ns     <= 1'b0;
        end else begin
            if (w_enter_ew_pregrn) begin
                r_last_served <= SERVED_EW;
            end else if (w_enter_walk) begin
                r_last_served <= SERVED_PED;
            end
            if (w_enter_all_red) begin
                r_from_ns <= (r_state == NS_YELLOW);
            end
        end
    end

    // Signal heads decode from the phase register only
    always_comb begin
        o_ns_light = RED;
        o_ew_light = RED;
        o_walk     = 1'b0;
        unique case (r_state)
            NS_GREEN:  o_ns_light = GREEN;
            NS_YELLOW: o_ns_light = YELLOW;
            ALL_RED:   ;
            EW_PREGRN: o_ew_light = PRE_GREEN;
            EW_GREEN:  o_ew_light = GREEN;
            EW_YELLOW: o_ew_light = YELLOW;
            WALK:      o_walk     = 1'b1;
            NS_PREGRN: o_ns_light = PRE_GREEN;
            default:   ;
        endcase
    end

endmodule
